// File: rtl/sbm_result_serializer_pkg.sv
// Shared definitions for the sbm_digitized family: product/word defaults and
// the result-serializer FSM state encoding.
package sbm_result_serializer_pkg;

   localparam int SBM_SIZEC = 2048;
   localparam int SBM_WORD  = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2
   } sbm_state_t;

endpackage

// File: rtl/sbm_result_serializer.sv
// Captures a full multiplier product and streams it out LSW-first as WORD-bit
// words over a valid/ready handshake, flagging products offered while busy.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_IDLE  | waiting for a product; c_ready=1
// ST_SEND  | presenting word cnt of the captured product; dout_valid=1
// ST_DRAIN | one dead cycle after the last word; offers count as overrun
module sbm_result_serializer
   import sbm_result_serializer_pkg::*;
#(
   parameter int SIZEC = SBM_SIZEC,
   parameter int WORD  = SBM_WORD,
   parameter int WORDS = SIZEC / WORD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SIZEC-1:0] c_in,
   input  logic             c_valid,
   output logic             c_ready,
   output logic [WORD-1:0]  dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_last,
   output logic             overrun
);

   localparam int            CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   sbm_state_t       state, state_nxt;
   logic [SIZEC-1:0] sreg, sreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             ovr, ovr_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         sreg  <= '0;
         cnt   <= '0;
         ovr   <= 1'b0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
         ovr   <= ovr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      ovr_nxt   = ovr;
      if (c_valid && (state != ST_IDLE))
         ovr_nxt = 1'b1;
      case (state)
         ST_IDLE: begin
            if (c_valid) begin
               sreg_nxt  = c_in;
               cnt_nxt   = '0;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (dout_ready) begin
               // the last word is not shifted out; the counter parks at LAST
               if (cnt == LAST) begin
                  state_nxt = ST_DRAIN;
               end else begin
                  sreg_nxt = sreg >> WORD;
                  cnt_nxt  = cnt + 1'b1;
               end
            end
         end
         ST_DRAIN: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign c_ready    = (state == ST_IDLE);
   assign dout_valid = (state == ST_SEND);
   assign dout       = sreg[WORD-1:0];
   assign dout_last  = (state == ST_SEND) && (cnt == LAST);
   assign overrun    = ovr;

endmodule

// File: tb/tb_sbm_result_serializer.sv
// Randomized bench for sbm_result_serializer against a transaction-level model
// (queue of pending words, one-cycle drain, sticky overrun).
module tb_sbm_result_serializer;

   localparam int SIZEC = 2048;
   localparam int WORD  = 64;
   localparam int WORDS = SIZEC / WORD;

   logic             clk = 1'b0;
   logic             rst;
   logic [SIZEC-1:0] c_in;
   logic             c_valid;
   logic             c_ready;
   logic [WORD-1:0]  dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             dout_last;
   logic             overrun;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WORD-1:0] mq[$];
   bit              m_drain;
   bit              m_ovr;

   sbm_result_serializer #(.SIZEC(SIZEC), .WORD(WORD), .WORDS(WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .c_in       (c_in),
      .c_valid    (c_valid),
      .c_ready    (c_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_drain = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic check_outputs();
      check_eq("dout_valid", 64'(dout_valid), 64'(mq.size() > 0));
      check_eq("dout_last",  64'(dout_last),  64'(mq.size() == 1));
      check_eq("c_ready",    64'(c_ready),    64'((mq.size() == 0) && !m_drain));
      check_eq("overrun",    64'(overrun),    64'(m_ovr));
      if (mq.size() > 0)
         check_eq("dout", 64'(dout), 64'(mq[0]));
   endtask

   // Apply inputs for one clock, advance the model at the edge, check at negedge.
   task automatic step(input logic cv, input logic [SIZEC-1:0] cin, input logic dr);
      bit rdy, had, clr;
      c_valid    = cv;
      c_in       = cin;
      dout_ready = dr;
      @(posedge clk);
      rdy = (mq.size() == 0) && !m_drain;
      had = (mq.size() > 0);
      clr = m_drain;
      if (had && dr) begin
         void'(mq.pop_front());
         if (mq.size() == 0) m_drain = 1'b1;
      end
      if (clr) m_drain = 1'b0;
      if (cv && rdy) begin
         for (int k = 0; k < WORDS; k++) mq.push_back(cin[k*WORD +: WORD]);
      end else if (cv) begin
         m_ovr = 1'b1;
      end
      @(negedge clk);
      check_outputs();
   endtask

   function automatic logic [SIZEC-1:0] rand_product();
      logic [SIZEC-1:0] p;
      for (int k = 0; k < SIZEC / 32; k++) p[k*32 +: 32] = $urandom;
      return p;
   endfunction

   function automatic logic [SIZEC-1:0] index_product();
      logic [SIZEC-1:0] p;
      for (int k = 0; k < WORDS; k++) p[k*WORD +: WORD] = WORD'(k);
      return p;
   endfunction

   initial begin
      logic [SIZEC-1:0] p0, p1, ones;
      int n;
      rst = 1'b0; c_valid = 1'b0; c_in = '0; dout_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("reset_dout", 64'(dout), 64'd0);
      check_outputs();
      rst = 1'b1;
      step(1'b0, '0, 1'b1);

      // index product, consumer always ready
      p0 = index_product();
      step(1'b1, p0, 1'b1);
      for (int i = 0; i < WORDS + 3; i++) step(1'b0, '0, 1'b1);

      // same product, ready toggling 1/0: count valid cycles until the drain
      step(1'b1, p0, 1'b0);
      n = 0;
      while (dout_valid && n < 200) begin
         step(1'b0, '0, (n % 2) == 0);
         n++;
      end
      check_eq("toggle_cycles", 64'(n), 64'd63);
      repeat (2) step(1'b0, '0, 1'b0);

      // overrun offered during word 5; original product must keep streaming
      p0 = rand_product();
      p1 = rand_product();
      step(1'b1, p0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      step(1'b1, p1, 1'b0);
      for (int i = 0; i < WORDS + 4; i++) step(1'b0, '0, 1'b1);
      check_eq("overrun_sticky", 64'(overrun), 64'd1);

      // reset mid-transfer after word 10
      step(1'b1, p1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      rst = 1'b0;
      #1;
      model_reset();
      check_eq("rst_async_valid", 64'(dout_valid), 64'd0);
      check_eq("rst_async_ovr",   64'(overrun),    64'd0);
      check_eq("rst_async_ready", 64'(c_ready),    64'd1);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      p0 = rand_product();
      step(1'b1, p0, 1'b1);
      for (int i = 0; i < WORDS + 3; i++) step(1'b0, '0, 1'b1);

      // all-ones with c_valid held high: recapture right after the drain
      ones = '1;
      for (int i = 0; i < 2 * WORDS + 8; i++) step(1'b1, ones, 1'b1);
      for (int i = 0; i < WORDS + 4; i++) step(1'b0, '0, 1'b1);

      // random traffic after a fresh reset
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 15) == 0), rand_product(), ($urandom_range(0, 3) != 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
